// File: rtl/qubit_swap_pipelined_pkg.sv
// Shared definitions for the qubit-swap pipeline: mode encodings, the internal
// routing selector, amplitude packing macros and the bit-reverse index helper.

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

// Whole amplitude k (real and imag together) inside a packed state vector.
`define QS_AMP(k, w)    ((k) * 2 * (w)) +: (2 * (w))
// Real component of amplitude k (upper half of the amplitude).
`define QS_AMP_RE(k, w) (((k) * 2 * (w)) + (w)) +: (w)
// Imaginary component of amplitude k (lower half of the amplitude).
`define QS_AMP_IM(k, w) ((k) * 2 * (w)) +: (w)

package qubit_swap_pipelined_pkg;

   // Configuration modes sampled with each beat.
   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_SWAP   = 2'd1,
      MODE_BITREV = 2'd2,
      MODE_RSVD   = 2'd3
   } qs_mode_e;

   // Routing choice after the configuration has been validated.
   typedef enum logic [1:0] {
      SEL_IDENT = 2'd0,
      SEL_SWAP  = 2'd1,
      SEL_REV   = 2'd2
   } qs_sel_e;

   // Index with its low n bits reversed; evaluated at elaboration time only.
   function automatic int unsigned rev_idx(input int unsigned idx, input int unsigned n);
      int unsigned r;
      r = 32'd0;
      for (int unsigned i = 32'd0; i < n; i++) begin
         r = (r << 1) | ((idx >> i) & 32'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/qubit_swap_pipelined_perm.sv
// Combinational index-permutation network: output slot j takes input
// amplitude p(j). Validates the configuration and raises err for bad setups.

module qswap_perm
   import qubit_swap_pipelined_pkg::*;
#(
   parameter  int N_QUBITS = 3,
   parameter  int WIDTH    = `TOTAL_WIDTH,
   localparam int NAMP     = 1 << N_QUBITS,
   localparam int QW       = ($clog2(N_QUBITS) > 1) ? $clog2(N_QUBITS) : 1,
   localparam int AW       = 2 * WIDTH,
   localparam int VW       = NAMP * AW
)(
   input  logic [VW-1:0] in_amp,
   input  logic [1:0]    cfg_mode,
   input  logic [QW-1:0] cfg_qa,
   input  logic [QW-1:0] cfg_qb,
   output logic [VW-1:0] out_amp,
   output logic          out_err
);

   logic [AW-1:0] amp_in_s [NAMP];
   logic [2:0]    qa_s;
   logic [2:0]    qb_s;
   qs_sel_e       sel_s;

   assign qa_s = 3'(cfg_qa);
   assign qb_s = 3'(cfg_qb);

   for (genvar k = 0; k < NAMP; k++) begin : g_in
      assign amp_in_s[k] = in_amp[`QS_AMP(k, WIDTH)];
   end

   // Decode the mode into a routing choice; out-of-range qubits fall back to identity.
   always_comb begin
      sel_s   = SEL_IDENT;
      out_err = 1'b0;
      case (qs_mode_e'(cfg_mode))
         MODE_BYPASS: begin
            sel_s   = SEL_IDENT;
            out_err = 1'b0;
         end
         MODE_SWAP: begin
            if ((qa_s >= 3'(N_QUBITS)) || (qb_s >= 3'(N_QUBITS))) begin
               sel_s   = SEL_IDENT;
               out_err = 1'b1;
            end else begin
               sel_s   = SEL_SWAP;
               out_err = 1'b0;
            end
         end
         MODE_BITREV: begin
            sel_s   = SEL_REV;
            out_err = 1'b0;
         end
         MODE_RSVD: begin
            sel_s   = SEL_IDENT;
            out_err = 1'b1;
         end
         default: begin
            sel_s   = SEL_IDENT;
            out_err = 1'b1;
         end
      endcase
   end

   for (genvar j = 0; j < NAMP; j++) begin : g_out
      localparam logic [N_QUBITS-1:0] J_IDX   = N_QUBITS'(j);
      localparam logic [N_QUBITS-1:0] REV_IDX = N_QUBITS'(rev_idx(j, N_QUBITS));
      localparam logic [7:0]          J8      = 8'(j);
      logic [N_QUBITS-1:0] src_s;

      // Source index for output slot j; qa==qb naturally collapses to identity.
      always_comb begin
         src_s = J_IDX;
         case (sel_s)
            SEL_SWAP: begin
               for (int b = 0; b < N_QUBITS; b++) begin
                  if (3'(b) == qa_s) begin
                     src_s[b] = J8[qb_s];
                  end else if (3'(b) == qb_s) begin
                     src_s[b] = J8[qa_s];
                  end else begin
                     src_s[b] = J8[b];
                  end
               end
            end
            SEL_REV:   src_s = REV_IDX;
            SEL_IDENT: src_s = J_IDX;
            default:   src_s = J_IDX;
         endcase
      end

      assign out_amp[`QS_AMP(j, WIDTH)] = amp_in_s[src_s];
   end

endmodule

// File: rtl/qubit_swap_pipelined.sv
// Qubit-swap stage for the QFT datapath: permutation mux in front of an
// elastic valid/ready chain of STAGES register slices with full backpressure.

module qubit_swap_pipelined
   import qubit_swap_pipelined_pkg::*;
#(
   parameter  int N_QUBITS = 3,
   parameter  int WIDTH    = `TOTAL_WIDTH,
   parameter  int STAGES   = 2,
   localparam int NAMP     = 1 << N_QUBITS,
   localparam int QW       = ($clog2(N_QUBITS) > 1) ? $clog2(N_QUBITS) : 1,
   localparam int VW       = NAMP * 2 * WIDTH
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [VW-1:0] in_amp,
   input  logic [1:0]    cfg_mode,
   input  logic [QW-1:0] cfg_qa,
   input  logic [QW-1:0] cfg_qb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] out_amp,
   output logic          out_err
);

   logic [VW-1:0]     perm_amp_s;
   logic              perm_err_s;
   logic [STAGES:0]   rdy_s;
   logic [STAGES-1:0] vld_s;
   logic [STAGES-1:0] err_s;
   logic [VW-1:0]     dat_s [STAGES];

   qswap_perm #(
      .N_QUBITS (N_QUBITS),
      .WIDTH    (WIDTH)
   ) u_perm (
      .in_amp   (in_amp),
      .cfg_mode (cfg_mode),
      .cfg_qa   (cfg_qa),
      .cfg_qb   (cfg_qb),
      .out_amp  (perm_amp_s),
      .out_err  (perm_err_s)
   );

   // A slice may advance when it is empty or everything downstream of it can advance.
   always_comb begin
      rdy_s         = {(STAGES + 1){1'b0}};
      rdy_s[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy_s[k] = ~vld_s[k] | rdy_s[k + 1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic          up_vld_s;
      logic          up_err_s;
      logic [VW-1:0] up_dat_s;
      logic          vld_d, vld_q;
      logic          err_d, err_q;
      logic [VW-1:0] dat_d, dat_q;

      if (k == 0) begin : g_head
         assign up_vld_s = in_valid;
         assign up_err_s = perm_err_s;
         assign up_dat_s = perm_amp_s;
      end else begin : g_body
         assign up_vld_s = vld_s[k - 1];
         assign up_err_s = err_s[k - 1];
         assign up_dat_s = dat_s[k - 1];
      end

      // Take the upstream beat when this slice can advance; data only changes for real beats.
      always_comb begin
         vld_d = vld_q;
         err_d = err_q;
         dat_d = dat_q;
         if (rdy_s[k]) begin
            vld_d = up_vld_s;
            if (up_vld_s) begin
               err_d = up_err_s;
               dat_d = up_dat_s;
            end else begin
               err_d = err_q;
               dat_d = dat_q;
            end
         end else begin
            vld_d = vld_q;
            err_d = err_q;
            dat_d = dat_q;
         end
      end

      // Slice register; reset discards any in-flight beat immediately.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= {VW{1'b0}};
         end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            dat_q <= dat_d;
         end
      end

      assign vld_s[k] = vld_q;
      assign err_s[k] = err_q;
      assign dat_s[k] = dat_q;
   end

   assign in_ready  = rdy_s[0];
   assign out_valid = vld_s[STAGES - 1];
   assign out_err   = err_s[STAGES - 1];
   assign out_amp   = dat_s[STAGES - 1];

endmodule

// File: tb/tb_qubit_swap_pipelined.sv
// Bench for qubit_swap_pipelined: a 3-qubit/2-slice and a 4-qubit/3-slice
// instance, directed scenarios plus a random stream, both checked against
// an arithmetic reference model with per-instance expectation queues.

module tb_qubit_swap_pipelined;

   localparam int W  = 16;
   localparam int AW = 2 * W;

   typedef struct packed {
      logic         err;
      logic [511:0] amp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic         in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
   logic [255:0] in_amp3, out_amp3;
   logic [1:0]   cfg_mode3, cfg_qa3, cfg_qb3;
   logic         in_valid4, in_ready4, out_valid4, out_ready4, out_err4;
   logic [511:0] in_amp4, out_amp4;
   logic [1:0]   cfg_mode4, cfg_qa4, cfg_qb4;

   int   checks = 0;
   int   errors = 0;
   int   pops3  = 0;
   int   pops4  = 0;
   exp_t q3 [$];
   exp_t q4 [$];

   always #5 clk = ~clk;

   qubit_swap_pipelined #(.N_QUBITS(3), .WIDTH(W), .STAGES(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_amp(in_amp3), .cfg_mode(cfg_mode3), .cfg_qa(cfg_qa3), .cfg_qb(cfg_qb3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_amp(out_amp3), .out_err(out_err3)
   );

   qubit_swap_pipelined #(.N_QUBITS(4), .WIDTH(W), .STAGES(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_amp(in_amp4), .cfg_mode(cfg_mode4), .cfg_qa(cfg_qa4), .cfg_qb(cfg_qb4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_amp(out_amp4), .out_err(out_err4)
   );

   // Compare an observed value against its expectation and count the outcome.
   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Watchdog: flag an expired wait if the run never reaches its end.
   initial begin
      #1000000;
      errors++;
      $error("FAIL timeout: simulation did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Reference: out index j takes in index p(j), computed with plain arithmetic.
   function automatic void model(input logic [511:0] vin, input int n, input int mode,
                                 input int qa, input int qb,
                                 output logic [511:0] vout, output logic err);
      int src;
      vout = '0;
      err  = 1'b0;
      for (int j = 0; j < (1 << n); j++) begin
         src = j;
         if (mode == 1) begin
            if (qa >= n || qb >= n) begin
               err = 1'b1;
            end else begin
               int ba, bb;
               ba  = (j / (1 << qa)) % 2;
               bb  = (j / (1 << qb)) % 2;
               src = j - ba * (1 << qa) - bb * (1 << qb) + bb * (1 << qa) + ba * (1 << qb);
            end
         end else if (mode == 2) begin
            src = 0;
            for (int i = 0; i < n; i++) src = src * 2 + (j / (1 << i)) % 2;
         end else if (mode == 3) begin
            err = 1'b1;
         end
         vout[j*AW +: AW] = vin[src*AW +: AW];
      end
   endfunction

   // One clock cycle: drive at the negedge, check pops, record acceptances.
   task automatic cyc(input int which, input logic iv, input logic [511:0] amp, input int m,
                      input int qa, input int qb, input logic ordy, output logic acc);
      exp_t e;
      in_valid3  = (which == 3) && iv;
      in_valid4  = (which == 4) && iv;
      in_amp3    = amp[255:0];
      in_amp4    = amp;
      cfg_mode3  = m[1:0];
      cfg_mode4  = m[1:0];
      cfg_qa3    = qa[1:0];
      cfg_qa4    = qa[1:0];
      cfg_qb3    = qb[1:0];
      cfg_qb4    = qb[1:0];
      out_ready3 = ordy;
      out_ready4 = ordy;
      #1;
      if (out_valid3 && out_ready3) begin
         pops3++;
         chk("pop3_expected", (q3.size() > 0), 1'b1);
         if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("beat3", {out_err3, out_amp3}, {e.err, e.amp[255:0]});
         end
      end
      if (out_valid4 && out_ready4) begin
         pops4++;
         chk("pop4_expected", (q4.size() > 0), 1'b1);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("beat4", {out_err4, out_amp4}, {e.err, e.amp});
         end
      end
      acc = (which == 3) ? (iv && in_ready3) : ((which == 4) ? (iv && in_ready4) : 1'b0);
      if (acc) begin
         model(amp, (which == 3) ? 3 : 4, m, qa, qb, e.amp, e.err);
         if (which == 3) q3.push_back(e);
         else            q4.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic         acc;
      logic [511:0] v, exp_v;
      logic [511:0] bp [5];
      int           src3 [8];
      int           src4 [16];
      int           bp_mode [5];
      int           bp_qa [5];
      int           bp_qb [5];
      int           nacc, p0;

      src3    = '{0, 4, 2, 6, 1, 5, 3, 7};
      src4    = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      bp_mode = '{0, 1, 2, 1, 3};
      bp_qa   = '{0, 0, 0, 1, 0};
      bp_qb   = '{0, 1, 0, 2, 0};

      rst_n = 1'b0;
      in_valid3 = 1'b0; in_amp3 = '0; cfg_mode3 = 2'd0; cfg_qa3 = 2'd0; cfg_qb3 = 2'd0; out_ready3 = 1'b1;
      in_valid4 = 1'b0; in_amp4 = '0; cfg_mode4 = 2'd0; cfg_qa4 = 2'd0; cfg_qb4 = 2'd0; out_ready4 = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_out_valid3", out_valid3, 1'b0);
      chk("rst_out_amp3", out_amp3, 256'd0);
      chk("rst_out_err3", out_err3, 1'b0);
      chk("rst_in_ready3", in_ready3, 1'b1);
      chk("rst_out_valid4", out_valid4, 1'b0);

      // Legacy pair swap qa=0, qb=2, amp[k] = {k, -k}, latency 2
      v = '0;
      for (int k = 0; k < 8; k++) v[k*AW +: AW] = {16'(k), 16'(-k)};
      exp_v = '0;
      for (int j = 0; j < 8; j++) exp_v[j*AW +: AW] = v[src3[j]*AW +: AW];
      cyc(3, 1'b1, v, 1, 0, 2, 1'b1, acc);
      chk("swap_accept", acc, 1'b1);
      chk("swap_lat1_valid", out_valid3, 1'b0);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("swap_lat2_valid", out_valid3, 1'b1);
      chk("swap_amp", out_amp3, exp_v[255:0]);
      chk("swap_err", out_err3, 1'b0);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);

      // Bit-reverse on 4 qubits, amp[k] = {k, k}, latency 3
      v = '0;
      for (int k = 0; k < 16; k++) v[k*AW +: AW] = {16'(k), 16'(k)};
      exp_v = '0;
      for (int j = 0; j < 16; j++) exp_v[j*AW +: AW] = v[src4[j]*AW +: AW];
      cyc(4, 1'b1, v, 2, 0, 0, 1'b1, acc);
      chk("rev_accept", acc, 1'b1);
      chk("rev_lat1_valid", out_valid4, 1'b0);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("rev_lat2_valid", out_valid4, 1'b0);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("rev_lat3_valid", out_valid4, 1'b1);
      chk("rev_amp", out_amp4, exp_v);
      chk("rev_err", out_err4, 1'b0);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);

      // Bad and degenerate configurations on 3 qubits
      v = '0;
      for (int k = 0; k < 8; k++) v[k*AW +: AW] = {16'(k + 100), 16'(-k - 100)};
      cyc(3, 1'b1, v, 1, 1, 3, 1'b1, acc);
      cyc(3, 1'b1, v, 3, 0, 0, 1'b1, acc);
      chk("badq_amp", out_amp3, v[255:0]);
      chk("badq_err", out_err3, 1'b1);
      cyc(3, 1'b1, v, 1, 2, 2, 1'b1, acc);
      chk("rsvd_amp", out_amp3, v[255:0]);
      chk("rsvd_err", out_err3, 1'b1);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("sameq_amp", out_amp3, v[255:0]);
      chk("sameq_err", out_err3, 1'b0);
      cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);

      // Backpressure: five beats, out_ready held low for four cycles
      for (int b = 0; b < 5; b++) begin
         bp[b] = '0;
         for (int k = 0; k < 8; k++) bp[b][k*AW +: AW] = 32'($urandom);
      end
      nacc = 0;
      for (int c = 0; c < 4; c++) begin
         cyc(3, 1'b1, bp[nacc], bp_mode[nacc], bp_qa[nacc], bp_qb[nacc], 1'b0, acc);
         if (acc) nacc++;
         if (c == 1) begin
            chk("bp_accepted", nacc, 2);
            chk("bp_out_valid", out_valid3, 1'b1);
         end
         if (c >= 1) begin
            chk("bp_in_ready", in_ready3, 1'b0);
            chk("bp_stable_amp", {out_err3, out_amp3}, {q3[0].err, q3[0].amp[255:0]});
         end
      end
      for (int c = 0; c < 20 && nacc < 5; c++) begin
         cyc(3, 1'b1, bp[nacc], bp_mode[nacc], bp_qa[nacc], bp_qb[nacc], 1'b1, acc);
         if (acc) nacc++;
      end
      chk("bp_all_accepted", nacc, 5);
      repeat (4) cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("bp_drained", q3.size(), 0);

      // Full-rate stream: 16 back-to-back beats leave in 16 consecutive cycles
      p0   = pops3;
      nacc = 0;
      for (int i = 0; i < 16; i++) begin
         v = '0;
         for (int k = 0; k < 8; k++) v[k*AW +: AW] = 32'($urandom);
         cyc(3, 1'b1, v, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)), 1'b1, acc);
         if (acc) nacc++;
      end
      chk("fr_accepted", nacc, 16);
      repeat (2) cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("fr_no_bubbles", pops3 - p0, 16);

      // Random traffic on both instances with random backpressure
      for (int c = 0; c < 400; c++) begin
         v = '0;
         for (int k = 0; k < 16; k++) v[k*AW +: AW] = 32'($urandom);
         cyc(($urandom_range(1, 0) == 0) ? 3 : 4, 1'($urandom_range(1, 0)), v,
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
             ($urandom_range(3, 0) != 0), acc);
      end
      repeat (6) cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("rand_drained3", q3.size(), 0);
      chk("rand_drained4", q4.size(), 0);

      // Reset mid-stream with two beats in flight
      for (int i = 0; i < 2; i++) begin
         v = '0;
         for (int k = 0; k < 8; k++) v[k*AW +: AW] = 32'($urandom);
         cyc(3, 1'b1, v, 1, 0, 1, 1'b0, acc);
      end
      chk("mid_in_flight", out_valid3, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid3, 1'b0);
      chk("mid_rst_amp", out_amp3, 256'd0);
      chk("mid_rst_err", out_err3, 1'b0);
      q3.delete();
      q4.delete();
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_in_ready", in_ready3, 1'b1);
      p0 = pops3;
      repeat (5) cyc(0, 1'b0, v, 0, 0, 0, 1'b1, acc);
      chk("mid_no_stale", pops3 - p0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
